// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter for a fetch read port, an LSU read
// port and an LSU write port. The grant is held in a small registered FSM.
// The memory strobes come from that registered state. Payload and acks are
// steered combinationally from the granted requester. Every transaction is
// followed by one IDLE cycle. A starvation counter lets a waiting fetch win
// after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch read port
  input  logic              ir_re,
  input  logic [XLEN/8-1:0] ir_sel,
  input  logic [XLEN-1:0]   ir_addr,
  output logic [XLEN-1:0]   ir_data,
  output logic              ir_ack,
  // LSU read port
  input  logic              dr_re,
  input  logic [XLEN/8-1:0] dr_sel,
  input  logic [XLEN-1:0]   dr_addr,
  output logic [XLEN-1:0]   dr_data,
  output logic              dr_ack,
  // LSU write port
  input  logic              dw_we,
  input  logic [XLEN/8-1:0] dw_sel,
  input  logic [XLEN-1:0]   dw_addr,
  input  logic [XLEN-1:0]   dw_data,
  output logic              dw_ack,
  // memory port
  output logic              m_re,
  output logic              m_we,
  output logic [XLEN/8-1:0] m_sel,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  input  logic [XLEN-1:0]   m_rdata,
  input  logic              m_ack,
  output logic [1:0]        grant
);

  localparam int SW = XLEN / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G_IF = 2'd1,
    G_DR = 2'd2,
    G_DW = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] starve_cnt_r, starve_cnt_nxt_s;
  logic          starved_s;

  assign starved_s = ir_re && (starve_cnt_r == LIMIT_C);

  // Next-state: arbitrate only from IDLE, hold a grant until m_ack.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (starved_s)  state_nxt_s = G_IF;
        else if (dw_we) state_nxt_s = G_DW;
        else if (dr_re) state_nxt_s = G_DR;
        else if (ir_re) state_nxt_s = G_IF;
        else            state_nxt_s = IDLE;
      end
      G_IF, G_DR, G_DW: begin
        if (m_ack) state_nxt_s = IDLE;
        else       state_nxt_s = state_r;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Starvation counter: counts data grants issued while a fetch is waiting.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (state_r == IDLE) begin
      if (state_nxt_s == G_IF) begin
        starve_cnt_nxt_s = {CW{1'b0}};
      end else if (((state_nxt_s == G_DR) || (state_nxt_s == G_DW)) && ir_re) begin
        if (starve_cnt_r != LIMIT_C) starve_cnt_nxt_s = starve_cnt_r + ONE_C;
        else                         starve_cnt_nxt_s = starve_cnt_r;
      end else if (!ir_re) begin
        starve_cnt_nxt_s = {CW{1'b0}};
      end else begin
        starve_cnt_nxt_s = starve_cnt_r;
      end
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= {CW{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Output steering: reset forces everything low, so an ack during reset is lost.
  always_comb begin
    m_re    = 1'b0;
    m_we    = 1'b0;
    m_sel   = {SW{1'b0}};
    m_addr  = {XLEN{1'b0}};
    m_wdata = {XLEN{1'b0}};
    ir_ack  = 1'b0;
    dr_ack  = 1'b0;
    dw_ack  = 1'b0;
    ir_data = {XLEN{1'b0}};
    dr_data = {XLEN{1'b0}};
    grant   = 2'd0;
    if (!rst) begin
      grant = state_r;
      case (state_r)
        G_IF: begin
          m_re   = 1'b1;
          m_sel  = ir_sel;
          m_addr = ir_addr;
          ir_ack = m_ack;
          if (m_ack) ir_data = m_rdata;
          else       ir_data = {XLEN{1'b0}};
        end
        G_DR: begin
          m_re   = 1'b1;
          m_sel  = dr_sel;
          m_addr = dr_addr;
          dr_ack = m_ack;
          if (m_ack) dr_data = m_rdata;
          else       dr_data = {XLEN{1'b0}};
        end
        G_DW: begin
          m_we    = 1'b1;
          m_sel   = dw_sel;
          m_addr  = dw_addr;
          m_wdata = dw_data;
          dw_ack  = m_ack;
        end
        default: begin
          grant = 2'd0;
        end
      endcase
    end else begin
      grant = 2'd0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. The expected values below are
// worked out by hand from the arbiter's cycle behaviour.
module tb_mem_arbiter;
  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ir_re, dr_re, dw_we;
  logic [3:0]        ir_sel, dr_sel, dw_sel;
  logic [XLEN-1:0]   ir_addr, dr_addr, dw_addr, dw_data;
  logic [XLEN-1:0]   ir_data, dr_data;
  logic              ir_ack, dr_ack, dw_ack;
  logic              m_re, m_we;
  logic [3:0]        m_sel;
  logic [XLEN-1:0]   m_addr, m_wdata, m_rdata;
  logic              m_ack;
  logic [1:0]        grant;

  logic              mem_auto;
  logic              m_ack_man;

  int errors = 0;
  int checks = 0;

  // Zero-wait memory when mem_auto is set, otherwise a hand-driven ack.
  assign m_ack = mem_auto ? (m_re | m_we) : m_ack_man;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ir_re(ir_re), .ir_sel(ir_sel), .ir_addr(ir_addr), .ir_data(ir_data), .ir_ack(ir_ack),
    .dr_re(dr_re), .dr_sel(dr_sel), .dr_addr(dr_addr), .dr_data(dr_data), .dr_ack(dr_ack),
    .dw_we(dw_we), .dw_sel(dw_sel), .dw_addr(dw_addr), .dw_data(dw_data), .dw_ack(dw_ack),
    .m_re(m_re), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .grant(grant)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".grant"}, 64'(grant), 64'd0);
    check({tag, ".m_re"}, 64'(m_re), 64'd0);
    check({tag, ".m_we"}, 64'(m_we), 64'd0);
    check({tag, ".m_addr"}, 64'(m_addr), 64'd0);
    check({tag, ".acks"}, 64'({ir_ack, dr_ack, dw_ack}), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    ir_re = 1'b1; dr_re = 1'b0; dw_we = 1'b0;
    ir_sel = 4'h0; dr_sel = 4'h0; dw_sel = 4'h0;
    ir_addr = 32'h0; dr_addr = 32'h0; dw_addr = 32'h0; dw_data = 32'h0;
    m_rdata = 32'h0; mem_auto = 1'b0; m_ack_man = 1'b1;

    // Reset with a pending fetch and a stray ack: everything must stay low.
    tick(); tick();
    check_idle("rst");
    check("rst.ir_data", 64'(ir_data), 64'd0);
    check("rst.cnt", 64'(dut.starve_cnt_r), 64'd0);

    // First post-reset cycle: spurious ack in IDLE with no requests.
    ir_re = 1'b0;
    rst = 1'b0;
    #1;
    check_idle("spur0");
    tick();
    check_idle("spur1");
    m_ack_man = 1'b0;

    // Single fetch, acked on the first strobe cycle.
    ir_re = 1'b1; ir_addr = 32'h100; ir_sel = 4'hF;
    #1;
    check("if.pre_grant", 64'(grant), 64'd0);
    check("if.pre_m_re", 64'(m_re), 64'd0);
    tick();
    m_ack_man = 1'b1; m_rdata = 32'hDEADBEEF;
    #1;
    check("if.grant", 64'(grant), 64'd1);
    check("if.m_re", 64'(m_re), 64'd1);
    check("if.m_we", 64'(m_we), 64'd0);
    check("if.m_addr", 64'(m_addr), 64'h100);
    check("if.m_sel", 64'(m_sel), 64'hF);
    check("if.ir_ack", 64'(ir_ack), 64'd1);
    check("if.ir_data", 64'(ir_data), 64'hDEADBEEF);
    check("if.other_acks", 64'({dr_ack, dw_ack}), 64'd0);
    check("if.dr_data", 64'(dr_data), 64'd0);
    tick();
    ir_re = 1'b0; m_ack_man = 1'b0;
    #1;
    check_idle("if.after");
    check("if.ir_data0", 64'(ir_data), 64'd0);

    // Contention with zero-wait memory: write, bubble, read, bubble, fetch.
    mem_auto = 1'b1; m_rdata = 32'hA5A5_0001;
    ir_re = 1'b1; ir_addr = 32'h104; ir_sel = 4'hF;
    dr_re = 1'b1; dr_addr = 32'h880; dr_sel = 4'h1;
    dw_we = 1'b1; dw_addr = 32'h990; dw_sel = 4'hC; dw_data = 32'hCAFE_F00D;
    tick();
    check("ct1.grant", 64'(grant), 64'd3);
    check("ct1.m_we", 64'(m_we), 64'd1);
    check("ct1.m_wdata", 64'(m_wdata), 64'hCAFEF00D);
    check("ct1.m_sel", 64'(m_sel), 64'hC);
    check("ct1.acks", 64'({ir_ack, dr_ack, dw_ack}), 64'b001);
    dw_we = 1'b0;
    tick();
    check("ct2.grant", 64'(grant), 64'd0);
    tick();
    check("ct3.grant", 64'(grant), 64'd2);
    check("ct3.m_addr", 64'(m_addr), 64'h880);
    check("ct3.acks", 64'({ir_ack, dr_ack, dw_ack}), 64'b010);
    check("ct3.dr_data", 64'(dr_data), 64'hA5A50001);
    check("ct3.ir_data", 64'(ir_data), 64'd0);
    dr_re = 1'b0;
    tick();
    check("ct4.grant", 64'(grant), 64'd0);
    tick();
    check("ct5.grant", 64'(grant), 64'd1);
    check("ct5.acks", 64'({ir_ack, dr_ack, dw_ack}), 64'b100);
    check("ct5.cnt", 64'(dut.starve_cnt_r), 64'd0);
    ir_re = 1'b0;
    tick();
    check("ct6.grant", 64'(grant), 64'd0);

    // Starvation: fetch waits behind four data reads, then wins.
    ir_re = 1'b1; dr_re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sv%0d.grant", i), 64'(grant), 64'd2);
      check($sformatf("sv%0d.cnt", i), 64'(dut.starve_cnt_r), 64'(i + 1));
      tick();
      check($sformatf("sv%0d.bubble", i), 64'(grant), 64'd0);
    end
    tick();
    check("sv.if_grant", 64'(grant), 64'd1);
    check("sv.cnt0", 64'(dut.starve_cnt_r), 64'd0);
    ir_re = 1'b0; dr_re = 1'b0;
    tick();
    check("sv.end", 64'(grant), 64'd0);

    // Write with three wait states, then a single ack.
    mem_auto = 1'b0; m_ack_man = 1'b0;
    dw_we = 1'b1; dw_addr = 32'h200; dw_data = 32'h12345678; dw_sel = 4'h3;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ws%0d.grant", k), 64'(grant), 64'd3);
      check($sformatf("ws%0d.m_we", k), 64'({m_re, m_we}), 64'b01);
      check($sformatf("ws%0d.m_addr", k), 64'(m_addr), 64'h200);
      check($sformatf("ws%0d.m_wdata", k), 64'(m_wdata), 64'h12345678);
      check($sformatf("ws%0d.m_sel", k), 64'(m_sel), 64'h3);
      check($sformatf("ws%0d.acks", k), 64'({ir_ack, dr_ack, dw_ack}), 64'd0);
      tick();
    end
    m_ack_man = 1'b1;
    #1;
    check("ws.ack", 64'({ir_ack, dr_ack, dw_ack}), 64'b001);
    tick();
    dw_we = 1'b0; m_ack_man = 1'b0;
    #1;
    check("ws.after_grant", 64'(grant), 64'd0);
    check("ws.after_ack", 64'(dw_ack), 64'd0);

    // Reset in the middle of a read; the ack during reset must be lost.
    dr_re = 1'b1; dr_addr = 32'h300; dr_sel = 4'hF; m_rdata = 32'h5555AAAA;
    tick();
    check("rr.grant", 64'(grant), 64'd2);
    rst = 1'b1; m_ack_man = 1'b1;
    #1;
    check_idle("rr.in_rst");
    check("rr.dr_data", 64'(dr_data), 64'd0);
    check("rr.m_sel", 64'(m_sel), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_idle("rr.post");
    m_ack_man = 1'b0;
    tick();
    check("rr.regrant", 64'(grant), 64'd2);
    check("rr.m_re", 64'(m_re), 64'd1);
    check("rr.m_addr", 64'(m_addr), 64'h300);
    check("rr.noack", 64'(dr_ack), 64'd0);
    m_ack_man = 1'b1;
    #1;
    check("rr.ack", 64'(dr_ack), 64'd1);
    check("rr.data", 64'(dr_data), 64'h5555AAAA);
    tick();
    dr_re = 1'b0;
    #1;

    // Spurious ack in IDLE with nothing requested.
    tick();
    check_idle("spur2");
    tick();
    check_idle("spur3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
